// File: rtl/spi_pwm_pkg.sv
// Shared frame geometry and register map for the SPI register slave and pwm_peripheral.
package spi_pwm_pkg;

  localparam int FRAME_BITS = 16;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;
  localparam int NUM_REGS   = 9;
  localparam int CNT_W      = 5;

  localparam int ADDR_EN_OUT      = 'h00;
  localparam int ADDR_EN_PWM      = 'h01;
  localparam int ADDR_CH_3_0      = 'h02;
  localparam int ADDR_CH_7_4      = 'h03;
  localparam int ADDR_G0_CH0_DUTY = 'h04;
  localparam int ADDR_G0_CH1_DUTY = 'h05;
  localparam int ADDR_G1_CH0_DUTY = 'h06;
  localparam int ADDR_G1_CH1_DUTY = 'h07;
  localparam int ADDR_FREQ_DIV    = 'h08;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int num_regs);
    return int'(addr) < num_regs;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for one asynchronous input, with a selectable reset level.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage_q;

  // NOTE: clocked state is written with <= so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) stage_q <= {STAGES{RESET_VAL}};
    else     stage_q <= {stage_q[STAGES-2:0], d};
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave decoding 16-bit frames into a 9-entry register file that drives pwm_peripheral.
module spi_reg_slave
  import spi_pwm_pkg::*;
#(
  parameter int NUM_REGS    = spi_pwm_pkg::NUM_REGS,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              ncs,
  input  logic              copi,
  output logic              cipo,
  output logic [DATA_W-1:0] reg_en_out,
  output logic [DATA_W-1:0] reg_en_pwm_out,
  output logic [DATA_W-1:0] reg_out_3_0_pwm_gen_channel,
  output logic [DATA_W-1:0] reg_out_7_4_pwm_gen_channel,
  output logic [DATA_W-1:0] reg_pwm_gen_0_ch_0_duty_cycle,
  output logic [DATA_W-1:0] reg_pwm_gen_0_ch_1_duty_cycle,
  output logic [DATA_W-1:0] reg_pwm_gen_1_ch_0_duty_cycle,
  output logic [DATA_W-1:0] reg_pwm_gen_1_ch_1_duty_cycle,
  output logic [DATA_W-1:0] reg_pwm_gen_1_0_frequency_divider,
  output logic              wr_pulse
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  logic sclk_s, ncs_s, copi_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .d(ncs), .q(ncs_s)
  );
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .d(copi), .q(copi_s)
  );

  logic                  sclk_prev_q, ncs_prev_q;
  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  overflow_q, overflow_d;
  logic                  is_read_q, is_read_d;
  logic [DATA_W-1:0]     read_q, read_d;
  logic                  cipo_q, cipo_d;
  logic                  wr_pulse_q, wr_pulse_d;
  logic [DATA_W-1:0]     regs_q [NUM_REGS];
  logic [DATA_W-1:0]     regs_d [NUM_REGS];

  logic              sclk_rise, sclk_fall, ncs_rise, ncs_fall, in_frame;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              commit_ok;

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign in_frame  = (state_q == ST_SHIFT);

  // Address is complete on the rise that shifts in its last bit, so include copi_s directly.
  assign rd_addr = {shift_q[ADDR_W-2:0], copi_s};

  assign commit_ok = (bit_cnt_q == CNT_W'(FRAME_BITS)) && !overflow_q && shift_q[FRAME_BITS-1]
                     && addr_in_range(shift_q[FRAME_BITS-2:DATA_W], NUM_REGS);

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = regs_q[i];
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    overflow_d = overflow_q;
    is_read_d  = is_read_q;
    read_d     = read_q;
    cipo_d     = cipo_q;
    wr_pulse_d = 1'b0;
    regs_d     = regs_q;

    if (state_q == ST_COMMIT) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (shift_q[FRAME_BITS-2:DATA_W] == ADDR_W'(i)) regs_d[i] = shift_q[DATA_W-1:0];
      end
      wr_pulse_d = 1'b1;
      state_d    = ST_IDLE;
    end

    // ncs edges take priority over any sclk edge seen in the same cycle.
    if (ncs_fall) begin
      state_d    = ST_SHIFT;
      bit_cnt_d  = '0;
      shift_d    = '0;
      overflow_d = 1'b0;
      is_read_d  = 1'b0;
    end else if (ncs_rise) begin
      if (in_frame) state_d = commit_ok ? ST_COMMIT : ST_IDLE;
    end else if (in_frame && !ncs_s) begin
      if (sclk_rise) begin
        if (bit_cnt_q == CNT_W'(FRAME_BITS)) begin
          overflow_d = 1'b1;
        end else begin
          shift_d   = {shift_q[FRAME_BITS-2:0], copi_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_W - 1) && !shift_q[DATA_W-2]) begin
            is_read_d = 1'b1;
            read_d    = rd_data;
          end
        end
      end else if (sclk_fall) begin
        if (is_read_q && bit_cnt_q >= CNT_W'(DATA_W) && bit_cnt_q < CNT_W'(FRAME_BITS)) begin
          cipo_d = read_q[DATA_W-1];
          read_d = {read_q[DATA_W-2:0], 1'b0};
        end else begin
          cipo_d = 1'b0;
        end
      end
    end

    if (ncs_s) cipo_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      overflow_q  <= 1'b0;
      is_read_q   <= 1'b0;
      read_q      <= '0;
      cipo_q      <= 1'b0;
      wr_pulse_q  <= 1'b0;
      // NOTE: the register array is reset because it drives the PWM stage directly.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      overflow_q  <= overflow_d;
      is_read_q   <= is_read_d;
      read_q      <= read_d;
      cipo_q      <= cipo_d;
      wr_pulse_q  <= wr_pulse_d;
      regs_q      <= regs_d;
    end
  end

  assign cipo     = cipo_q;
  assign wr_pulse = wr_pulse_q;

  assign reg_en_out                        = regs_q[ADDR_EN_OUT];
  assign reg_en_pwm_out                    = regs_q[ADDR_EN_PWM];
  assign reg_out_3_0_pwm_gen_channel       = regs_q[ADDR_CH_3_0];
  assign reg_out_7_4_pwm_gen_channel       = regs_q[ADDR_CH_7_4];
  assign reg_pwm_gen_0_ch_0_duty_cycle     = regs_q[ADDR_G0_CH0_DUTY];
  assign reg_pwm_gen_0_ch_1_duty_cycle     = regs_q[ADDR_G0_CH1_DUTY];
  assign reg_pwm_gen_1_ch_0_duty_cycle     = regs_q[ADDR_G1_CH0_DUTY];
  assign reg_pwm_gen_1_ch_1_duty_cycle     = regs_q[ADDR_G1_CH1_DUTY];
  assign reg_pwm_gen_1_0_frequency_divider = regs_q[ADDR_FREQ_DIV];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Scoreboard bench for spi_reg_slave: stimulus queues expected commits/reads, monitors pop and compare.
module tb_spi_reg_slave;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst, sclk, ncs, copi;
  logic cipo, wr_pulse;
  logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7, r8;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;

  wr_exp_t    exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] model [9];

  int         mon_bits = 0;
  logic       mon_rw   = 1'b1;
  logic [7:0] mon_rd   = '0;

  always #5 clk = ~clk;

  spi_reg_slave #(.NUM_REGS(9), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo),
    .reg_en_out(r0), .reg_en_pwm_out(r1),
    .reg_out_3_0_pwm_gen_channel(r2), .reg_out_7_4_pwm_gen_channel(r3),
    .reg_pwm_gen_0_ch_0_duty_cycle(r4), .reg_pwm_gen_0_ch_1_duty_cycle(r5),
    .reg_pwm_gen_1_ch_0_duty_cycle(r6), .reg_pwm_gen_1_ch_1_duty_cycle(r7),
    .reg_pwm_gen_1_0_frequency_divider(r8), .wr_pulse(wr_pulse)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_out(input int a);
    case (a)
      0: return r0;
      1: return r1;
      2: return r2;
      3: return r3;
      4: return r4;
      5: return r5;
      6: return r6;
      7: return r7;
      default: return r8;
    endcase
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    copi = b;
    wait_clk(4);
    sclk = 1'b1;
    wait_clk(4);
    sclk = 1'b0;
  endtask

  task automatic spi_xfer(input logic [31:0] frame, input int nbits, input int gap);
    ncs = 1'b0;
    wait_clk(4);
    for (int i = nbits - 1; i >= 0; i--) send_bit(frame[i]);
    wait_clk(4);
    ncs  = 1'b1;
    copi = 1'b0;
    wait_clk(gap);
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data, input int gap);
    wr_exp_t e;
    e.addr = addr;
    e.data = data;
    exp_wr_q.push_back(e);
    model[addr] = data;
    spi_xfer({16'h0, 1'b1, addr, data}, 16, gap);
  endtask

  task automatic spi_read(input logic [6:0] addr, input logic [7:0] exp);
    exp_rd_q.push_back(exp);
    spi_xfer({16'h0, 1'b0, addr, 8'h00}, 16, 8);
  endtask

  task automatic check_regs(input string tag);
    for (int a = 0; a < 9; a++) check($sformatf("%s_reg%0d", tag, a), reg_out(a), model[a]);
  endtask

  // Commit monitor: each wr_pulse must match the oldest expected write and last one cycle.
  initial begin
    wr_exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && wr_pulse === 1'b1) begin
        pulse_cnt++;
        if (exp_wr_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_wr_pulse: got pulse expected none");
        end else begin
          e = exp_wr_q.pop_front();
          check($sformatf("commit_addr%0d", e.addr), reg_out(int'(e.addr)), e.data);
        end
        @(negedge clk);
        check("wr_pulse_width", wr_pulse, 1'b0);
      end
    end
  end

  // Read monitor: rebuilds the byte on cipo as a mode-0 master would sample it.
  always @(negedge ncs) begin
    mon_bits = 0;
    mon_rd   = '0;
  end

  always @(posedge sclk) begin
    if (ncs === 1'b0) begin
      mon_bits++;
      if (mon_bits == 1) mon_rw = copi;
      if (mon_bits >= 9 && mon_bits <= 16) mon_rd = {mon_rd[6:0], cipo};
    end
  end

  always @(posedge ncs) begin
    if (mon_bits == 16 && mon_rw === 1'b0) begin
      if (exp_rd_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_read: got 0x%0h expected none", mon_rd);
      end else begin
        check("read_data", mon_rd, exp_rd_q.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
    for (int a = 0; a < 9; a++) model[a] = 8'h00;
    wait_clk(4);
    check_regs("reset");
    check("reset_wr_pulse", wr_pulse, 1'b0);
    check("reset_cipo", cipo, 1'b0);
    rst = 1'b0;
    wait_clk(4);

    // Single write to addr 0x01.
    spi_write(7'h01, 8'hA5, 8);
    check_regs("t1");
    check("t1_pulses", pulse_cnt, 1);

    // Write freq divider then read it back.
    spi_write(7'h08, 8'h3C, 8);
    spi_read(7'h08, 8'h3C);
    check_regs("t2");
    check("t2_pulses", pulse_cnt, 2);

    // Short (12-bit) and long (17-bit) frames to addr 0x04.
    spi_xfer(32'h845, 12, 8);
    spi_xfer(32'h108B5, 17, 8);
    check_regs("t3");
    check("t3_pulses", pulse_cnt, 2);

    // Out-of-range writes and read.
    spi_xfer(32'h89FF, 16, 8);
    spi_xfer(32'hFFEE, 16, 8);
    spi_read(7'h7F, 8'h00);
    check_regs("t4");
    check("t4_pulses", pulse_cnt, 2);

    // Reset mid-frame after 10 bits of a write to 0x00.
    ncs = 1'b0;
    wait_clk(4);
    for (int i = 15; i >= 6; i--) send_bit(logic'((16'h8055 >> i) & 16'h1));
    rst = 1'b1;
    wait_clk(2);
    for (int a = 0; a < 9; a++) model[a] = 8'h00;
    check_regs("t5_rst");
    check("t5_rst_wr_pulse", wr_pulse, 1'b0);
    rst = 1'b0;
    for (int i = 5; i >= 0; i--) send_bit(logic'((16'h8055 >> i) & 16'h1));
    wait_clk(4);
    ncs  = 1'b1;
    copi = 1'b0;
    wait_clk(8);
    check_regs("t5");
    check("t5_pulses", pulse_cnt, 2);

    // Back-to-back writes with a 4-clk ncs gap; commit order is checked by the monitor.
    spi_write(7'h06, 8'h77, 4);
    spi_write(7'h06, 8'h99, 8);
    spi_write(7'h02, 8'h5A, 8);
    check_regs("t6");
    check("t6_pulses", pulse_cnt, 5);

    check("wr_queue_drained", exp_wr_q.size(), 0);
    check("rd_queue_drained", exp_rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
